xmul_pipe: RTL and testbench

XMUL_PIPE -- requirements
Module: xmul_pipe

---
 rtl/xmul_pipe_if.sv | 30 +++
 rtl/xmul_pipe.sv | 85 ++++++++
 tb/tb_xmul_pipe.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xmul_pipe_if.sv
// Request/response bundle for xmul_pipe. Both directions use valid/ready: a beat moves
// on a cycle where valid && ready; the producer keeps valid and payload steady until then.
interface xmul_pipe_if #(
    parameter int XLEN = 64,
    parameter int TAGW = 5
) ();
    logic            req_valid;
    logic            req_ready;
    logic            req_dw;
    logic [5:0]      req_fn;
    logic [TAGW-1:0] req_tag;
    logic [XLEN-1:0] req_in1;
    logic [XLEN-1:0] req_in2;
    logic [XLEN-1:0] req_in3;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic [TAGW-1:0] resp_tag;
    logic            busy;

    modport master (
        output req_valid, req_dw, req_fn, req_tag, req_in1, req_in2, req_in3, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag, busy
    );

    modport slave (
        input  req_valid, req_dw, req_fn, req_tag, req_in1, req_in2, req_in3, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag, busy
    );
endinterface

// File: rtl/xmul_pipe.sv
// Pipelined integer multiply / multiply-add unit. The product and result select are
// computed ahead of stage 0; the LAT stages behind it only carry valid, data and tag.
module xmul_pipe #(
    parameter int XLEN = 64,
    parameter int LAT  = 2,
    parameter int TAGW = 5
) (
    input logic       clock,
    input logic       reset,
    xmul_pipe_if.slave bus
);
    localparam logic [5:0] FN_MUL    = 6'd0;
    localparam logic [5:0] FN_MULH   = 6'd1;
    localparam logic [5:0] FN_MULHSU = 6'd2;
    localparam logic [5:0] FN_MULHU  = 6'd3;
    localparam logic [5:0] FN_MADDL  = 6'd50;
    localparam logic [5:0] FN_MADDH  = 6'd51;
    localparam logic [5:0] FN_CADD   = 6'd52;

    logic              adv;
    logic              sign_a;
    logic              sign_b;
    logic              narrow;
    logic              cadd_carry;
    logic [2*XLEN-1:0] op_a;
    logic [2*XLEN-1:0] op_b;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] madd_sum;
    logic [XLEN-1:0]   res_d;

    logic [LAT-1:0]    valid_q;
    logic [XLEN-1:0]   data_q [LAT];
    logic [TAGW-1:0]   tag_q  [LAT];

    // One shared multiplier: operand extension picks signed/unsigned flavour.
    always_comb begin
        sign_a     = (bus.req_fn == FN_MULH) || (bus.req_fn == FN_MULHSU);
        sign_b     = (bus.req_fn == FN_MULH);
        op_a       = {{XLEN{sign_a & bus.req_in1[XLEN-1]}}, bus.req_in1};
        op_b       = {{XLEN{sign_b & bus.req_in2[XLEN-1]}}, bus.req_in2};
        prod       = op_a * op_b;
        madd_sum   = prod + {{XLEN{1'b0}}, bus.req_in3};
        cadd_carry = (bus.req_in1 > ~bus.req_in2);
        narrow     = (XLEN == 64) && !bus.req_dw;
        res_d      = '0;
        case (bus.req_fn)
            FN_MUL:    res_d = narrow ? XLEN'($signed(prod[31:0])) : prod[XLEN-1:0];
            FN_MULH,
            FN_MULHSU,
            FN_MULHU:  res_d = prod[2*XLEN-1:XLEN];
            FN_MADDL:  res_d = narrow ? XLEN'($signed(madd_sum[31:0])) : madd_sum[XLEN-1:0];
            FN_MADDH:  res_d = madd_sum[2*XLEN-1:XLEN];
            FN_CADD:   res_d = bus.req_in3 + XLEN'(cadd_carry);
            default:   res_d = '0;
        endcase
    end

    // The whole pipe moves as one; a held output freezes every stage behind it.
    assign adv = !valid_q[LAT-1] || bus.resp_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else if (adv) begin
            valid_q[0] <= bus.req_valid;
            data_q[0]  <= res_d;
            tag_q[0]   <= bus.req_tag;
            for (int i = 1; i < LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                data_q[i]  <= data_q[i-1];
                tag_q[i]   <= tag_q[i-1];
            end
        end
    end

    assign bus.req_ready  = adv;
    assign bus.resp_valid = valid_q[LAT-1];
    assign bus.resp_data  = data_q[LAT-1];
    assign bus.resp_tag   = tag_q[LAT-1];
    assign bus.busy       = |valid_q;
endmodule

// File: tb/tb_xmul_pipe.sv
// Bench for xmul_pipe: LAT=2 unit gets directed, stall, reset and random traffic;
// LAT=1 and LAT=4 units share the request stream for latency checks.
module tb_xmul_pipe;
    localparam int XLEN = 64;
    localparam int TAGW = 5;
    localparam int EW   = 1 + TAGW + XLEN;

    typedef struct {
        logic [5:0]  fn;
        logic        dw;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] exp;
    } vec_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_dw;
    logic [5:0]      req_fn;
    logic [TAGW-1:0] req_tag;
    logic [63:0]     in1, in2, in3;
    logic            rr2;
    int              checks = 0;
    int              errors = 0;
    logic [EW-1:0]   exp_q[$];

    always #5 clock = ~clock;

    xmul_pipe_if #(.XLEN(XLEN), .TAGW(TAGW)) b2 ();
    xmul_pipe_if #(.XLEN(XLEN), .TAGW(TAGW)) b1 ();
    xmul_pipe_if #(.XLEN(XLEN), .TAGW(TAGW)) b4 ();

    assign b2.req_valid = req_valid, b2.req_dw = req_dw, b2.req_fn = req_fn, b2.req_tag = req_tag,
           b2.req_in1 = in1, b2.req_in2 = in2, b2.req_in3 = in3, b2.resp_ready = rr2;
    assign b1.req_valid = req_valid, b1.req_dw = req_dw, b1.req_fn = req_fn, b1.req_tag = req_tag,
           b1.req_in1 = in1, b1.req_in2 = in2, b1.req_in3 = in3, b1.resp_ready = 1'b1;
    assign b4.req_valid = req_valid, b4.req_dw = req_dw, b4.req_fn = req_fn, b4.req_tag = req_tag,
           b4.req_in1 = in1, b4.req_in2 = in2, b4.req_in3 = in3, b4.resp_ready = 1'b1;

    xmul_pipe #(.XLEN(XLEN), .LAT(2), .TAGW(TAGW)) u_lat2 (.clock(clock), .reset(reset), .bus(b2.slave));
    xmul_pipe #(.XLEN(XLEN), .LAT(1), .TAGW(TAGW)) u_lat1 (.clock(clock), .reset(reset), .bus(b1.slave));
    xmul_pipe #(.XLEN(XLEN), .LAT(4), .TAGW(TAGW)) u_lat4 (.clock(clock), .reset(reset), .bus(b4.slave));

    // Reference: plain 128-bit arithmetic straight from the operation definitions.
    function automatic logic [63:0] model(input logic [5:0] fn, input logic dw,
                                          input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c);
        logic signed [127:0] p_ss;
        logic signed [127:0] p_su;
        logic [127:0]        p_uu;
        logic [127:0]        s;
        logic [64:0]         csum;
        logic [63:0]         r;
        p_ss = $signed(a) * $signed(b);
        p_su = $signed(a) * $signed({1'b0, b});
        p_uu = {64'd0, a} * {64'd0, b};
        s    = p_uu + {64'd0, c};
        csum = {1'b0, a} + {1'b0, b};
        case (fn)
            6'd0:    r = dw ? p_uu[63:0] : {{32{p_uu[31]}}, p_uu[31:0]};
            6'd1:    r = p_ss[127:64];
            6'd2:    r = p_su[127:64];
            6'd3:    r = p_uu[127:64];
            6'd50:   r = dw ? s[63:0] : {{32{s[31]}}, s[31:0]};
            6'd51:   r = s[127:64];
            6'd52:   r = c + {63'd0, csum[64]};
            default: r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return {32'd0, $urandom()};
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    function automatic logic [5:0] rand_fn();
        case ($urandom_range(0, 7))
            0: return 6'd0;
            1: return 6'd1;
            2: return 6'd2;
            3: return 6'd3;
            4: return 6'd50;
            5: return 6'd51;
            6: return 6'd52;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_dw = 1'b1; req_fn = 6'd0; req_tag = '0;
        in1 = '0; in2 = '0; in3 = '0;
    endtask

    task automatic drive(input logic [5:0] fn, input logic dw, input logic [TAGW-1:0] tag,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        req_valid = 1'b1; req_fn = fn; req_dw = dw; req_tag = tag;
        in1 = a; in2 = b; in3 = c;
    endtask

    task automatic drive_random();
        drive(rand_fn(), 1'($urandom_range(0, 1)), TAGW'($urandom_range(0, 31)), rand64(), rand64(), rand64());
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        rr2 = 1'b0;
        reset = 1'b1;
        drive(6'd0, 1'b1, 5'd3, 64'd7, 64'd6, 64'd0);
        tick();
        tick();
        checks++; if (b2.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", b2.resp_valid); end
        checks++; if (b2.resp_data !== 64'd0) begin errors++; $display("FAIL reset_resp_data got %h want 0", b2.resp_data); end
        checks++; if (b2.resp_tag !== 5'd0) begin errors++; $display("FAIL reset_resp_tag got %h want 0", b2.resp_tag); end
        checks++; if (b2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", b2.busy); end
        reset = 1'b0;
        idle();
        tick();
        checks++; if (b2.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", b2.req_ready); end
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (b2.resp_valid !== 1'b0 || b2.busy !== 1'b0) begin
                errors++; $display("FAIL reset_req_dropped cycle %0d valid %b busy %b want 0 0", t, b2.resp_valid, b2.busy);
            end
            tick();
        end
    endtask

    task automatic test_directed();
        vec_t vt[10];
        vt[0] = '{6'd51, 1'b1, '1, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[1] = '{6'd50, 1'b1, '1, '1, '1, 64'h0};
        vt[2] = '{6'd52, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd5, 64'd6};
        vt[3] = '{6'd1, 1'b1, '1, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[4] = '{6'd3, 1'b1, '1, 64'd2, 64'd0, 64'h1};
        vt[5] = '{6'd0, 1'b0, 64'h8000_0000, 64'd1, 64'd0, 64'hFFFF_FFFF_8000_0000};
        vt[6] = '{6'd0, 1'b1, 64'h8000_0000, 64'd1, 64'd0, 64'h0000_0000_8000_0000};
        vt[7] = '{6'd7, 1'b1, 64'd12, 64'd34, 64'd56, 64'h0};
        vt[8] = '{6'd2, 1'b1, '1, 64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        vt[9] = '{6'd50, 1'b0, 64'h7FFF_FFFF, 64'd1, 64'd1, 64'hFFFF_FFFF_8000_0000};
        do_reset();
        rr2 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            logic [TAGW-1:0] tg;
            tg = (i == 7) ? 5'd9 : TAGW'(i + 16);
            drive(vt[i].fn, vt[i].dw, tg, vt[i].a, vt[i].b, vt[i].c);
            tick();
            idle();
            checks++; if (b2.resp_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got %b want 0", i, b2.resp_valid); end
            tick();
            checks++; if (b2.resp_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid got %b want 1", i, b2.resp_valid); end
            checks++; if (b2.resp_data !== vt[i].exp) begin errors++; $display("FAIL dir%0d_data got %h want %h", i, b2.resp_data, vt[i].exp); end
            checks++; if (b2.resp_tag !== tg) begin errors++; $display("FAIL dir%0d_tag got %h want %h", i, b2.resp_tag, tg); end
            tick();
        end
    endtask

    task automatic test_latency();
        do_reset();
        rr2 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic [63:0] want;
            logic [TAGW-1:0] tg;
            want = (k == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0;
            tg = TAGW'(11 + k);
            drive((k == 0) ? 6'd51 : 6'd50, 1'b1, tg, '1, '1, '1);
            for (int t = 1; t <= 4; t++) begin
                tick();
                if (t == 1) idle();
                checks++;
                if (b1.resp_valid !== (t == 1)) begin errors++; $display("FAIL lat1_valid k%0d t%0d got %b want %b", k, t, b1.resp_valid, (t == 1)); end
                if (t == 1) begin
                    checks++;
                    if (b1.resp_data !== want || b1.resp_tag !== tg) begin
                        errors++; $display("FAIL lat1_data k%0d got %h/%h want %h/%h", k, b1.resp_data, b1.resp_tag, want, tg);
                    end
                end
                checks++;
                if (b4.resp_valid !== (t == 4)) begin errors++; $display("FAIL lat4_valid k%0d t%0d got %b want %b", k, t, b4.resp_valid, (t == 4)); end
                if (t == 4) begin
                    checks++;
                    if (b4.resp_data !== want || b4.resp_tag !== tg) begin
                        errors++; $display("FAIL lat4_data k%0d got %h/%h want %h/%h", k, b4.resp_data, b4.resp_tag, want, tg);
                    end
                end
            end
            tick();
        end
    endtask

    task automatic test_random_stream();
        logic [EW-1:0] e;
        do_reset();
        rr2 = 1'b1;
        exp_q.delete();
        for (int cyc = 0; cyc < 202; cyc++) begin
            if (cyc < 200 && $urandom_range(0, 3) != 0) begin
                drive_random();
                exp_q.push_back({1'b1, req_tag, model(req_fn, req_dw, in1, in2, in3)});
            end else begin
                idle();
                exp_q.push_back('0);
            end
            tick();
            if (exp_q.size() == 2) begin
                e = exp_q.pop_front();
                checks++;
                if (b2.resp_valid !== e[EW-1]) begin
                    errors++; $display("FAIL stream_valid cyc %0d got %b want %b", cyc, b2.resp_valid, e[EW-1]);
                end else if (e[EW-1] && (b2.resp_tag !== e[EW-2 -: TAGW] || b2.resp_data !== e[XLEN-1:0])) begin
                    errors++; $display("FAIL stream_data cyc %0d got %h/%h want %h/%h", cyc, b2.resp_tag, b2.resp_data, e[EW-2 -: TAGW], e[XLEN-1:0]);
                end
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0]   e;
        logic [63:0]     hold_d;
        logic [TAGW-1:0] hold_t;
        logic            accept, consume, stalled;
        int              idx, got;
        logic [5:0]      fns[4];
        fns[0] = 6'd0; fns[1] = 6'd1; fns[2] = 6'd51; fns[3] = 6'd52;
        do_reset();
        exp_q.delete();
        idx = 0;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            rr2 = (c >= 5);
            if (idx < 4 && !(req_valid && req_tag == TAGW'(idx + 1)))
                drive(fns[idx], 1'b1, TAGW'(idx + 1), rand64(), rand64(), rand64());
            else if (idx >= 4)
                idle();
            #1;
            if (c == 2) begin
                checks++; if (b2.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", b2.req_ready); end
            end
            accept  = req_valid && b2.req_ready;
            consume = b2.resp_valid && rr2;
            stalled = b2.resp_valid && !rr2;
            hold_d  = b2.resp_data;
            hold_t  = b2.resp_tag;
            if (accept) exp_q.push_back({1'b1, req_tag, model(req_fn, req_dw, in1, in2, in3)});
            if (consume) begin
                e = exp_q.pop_front();
                got++;
                checks++;
                if (b2.resp_tag !== TAGW'(got) || b2.resp_data !== e[XLEN-1:0]) begin
                    errors++; $display("FAIL b2b_order got %h/%h want %h/%h", b2.resp_tag, b2.resp_data, TAGW'(got), e[XLEN-1:0]);
                end
            end
            tick();
            if (accept) idx++;
            if (stalled) begin
                checks++;
                if (b2.resp_valid !== 1'b1 || b2.resp_data !== hold_d || b2.resp_tag !== hold_t) begin
                    errors++; $display("FAIL b2b_hold got %b/%h/%h want 1/%h/%h", b2.resp_valid, b2.resp_tag, b2.resp_data, hold_t, hold_d);
                end
            end
        end
        idle();
        checks++; if (got !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", got); end
        for (int t = 0; t < 4; t++) begin
            tick();
            checks++; if (b2.resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_duplicate got %b want 0", b2.resp_valid); end
        end
    endtask

    task automatic test_random_stall();
        logic [EW-1:0]   e;
        logic [63:0]     hold_d;
        logic [TAGW-1:0] hold_t;
        logic            accept, consume, stalled;
        do_reset();
        exp_q.delete();
        for (int c = 0; c < 340; c++) begin
            rr2 = (c >= 300) || ($urandom_range(0, 2) != 0);
            if (c < 300 && $urandom_range(0, 3) != 0) drive_random(); else idle();
            #1;
            accept  = req_valid && b2.req_ready;
            consume = b2.resp_valid && rr2;
            stalled = b2.resp_valid && !rr2;
            hold_d  = b2.resp_data;
            hold_t  = b2.resp_tag;
            if (accept) exp_q.push_back({1'b1, req_tag, model(req_fn, req_dw, in1, in2, in3)});
            if (consume) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL stall_extra got %h/%h want none", b2.resp_tag, b2.resp_data);
                end else begin
                    e = exp_q.pop_front();
                    if (b2.resp_tag !== e[EW-2 -: TAGW] || b2.resp_data !== e[XLEN-1:0]) begin
                        errors++; $display("FAIL stall_data got %h/%h want %h/%h", b2.resp_tag, b2.resp_data, e[EW-2 -: TAGW], e[XLEN-1:0]);
                    end
                end
            end
            tick();
            if (stalled) begin
                checks++;
                if (b2.resp_valid !== 1'b1 || b2.resp_data !== hold_d || b2.resp_tag !== hold_t) begin
                    errors++; $display("FAIL stall_hold got %b/%h/%h want 1/%h/%h", b2.resp_valid, b2.resp_tag, b2.resp_data, hold_t, hold_d);
                end
            end
        end
        idle();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_drain got %0d left want 0", exp_q.size()); end
        checks++; if (b2.busy !== 1'b0) begin errors++; $display("FAIL stall_busy got %b want 0", b2.busy); end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        rr2 = 1'b0;
        drive(6'd0, 1'b1, 5'd21, 64'd3, 64'd5, 64'd0);
        tick();
        drive(6'd3, 1'b1, 5'd22, 64'd9, 64'd9, 64'd0);
        tick();
        idle();
        checks++; if (b2.busy !== 1'b1 || b2.resp_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got %b/%b want 1/1", b2.busy, b2.resp_valid); end
        reset = 1'b1;
        tick();
        checks++; if (b2.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b want 0", b2.resp_valid); end
        checks++; if (b2.busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy got %b want 0", b2.busy); end
        reset = 1'b0;
        rr2 = 1'b1;
        for (int t = 0; t < 6; t++) begin
            tick();
            checks++; if (b2.resp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale cycle %0d got %b want 0", t, b2.resp_valid); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rr2 = 1'b1;
        reset = 1'b1;
        test_reset();
        test_directed();
        test_latency();
        test_random_stream();
        test_back_to_back();
        test_random_stall();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
